// File: rtl/mips_run_controller.sv
// Run sequencer for the single-cycle MIPS core: holds the core in reset, then runs it for a bounded
// number of cycles or until a halt PC, capturing a PC/ALU trace. Trace buffer built only with MIPS_RUN_TRACE_EN.
module mips_run_controller #(
    parameter int DATA_W      = 32,
    parameter int CNT_W       = 16,
    parameter int RST_CYCLES  = 2,
    parameter int TRACE_DEPTH = 16,
    localparam int AW         = $clog2(TRACE_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_cycles,
    input  logic              halt_en,
    input  logic [DATA_W-1:0] halt_pc,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [DATA_W-1:0] alu_result_in,
    output logic              cpu_rst,
    output logic              cpu_clk_en,
    output logic              busy,
    output logic              done,
    output logic              halted,
    output logic [CNT_W-1:0]  cycles_run,
    input  logic [AW-1:0]     trace_rd_addr,
    output logic [DATA_W-1:0] trace_pc,
    output logic [DATA_W-1:0] trace_alu,
    output logic [AW:0]       trace_count,
    output logic              trace_overflow
);

    localparam int RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RST_W-1:0]  RST_ZERO = {RST_W{1'b0}};
    localparam logic [RST_W-1:0]  RST_ONE  = RST_W'(1);
    localparam logic [RST_W-1:0]  RST_LAST = RST_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RST_HOLD = 2'd1,
        ST_RUN      = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    state_t              state_r;
    logic [RST_W-1:0]    rst_cnt_r;
    logic [CNT_W-1:0]    num_cycles_r;
    logic                halt_en_r;
    logic [DATA_W-1:0]   halt_pc_r;
    logic [CNT_W-1:0]    cycles_run_r;
    logic                busy_r;
    logic                done_r;
    logic                halted_r;
    logic                halt_hit_s;
    logic                run_step_s;

    // Halt detection against the PC the core presents this cycle.
    always_comb begin
        if ((state_r == ST_RUN) && halt_en_r && (pc_in == halt_pc_r)) begin
            halt_hit_s = 1'b1;
        end else begin
            halt_hit_s = 1'b0;
        end
    end

    // A run step is a RUN cycle in which the core is allowed to execute.
    always_comb begin
        if ((state_r == ST_RUN) && !halt_hit_s) begin
            run_step_s = 1'b1;
        end else begin
            run_step_s = 1'b0;
        end
    end

    // Clock enable stays combinational so the halting instruction is never clocked into the core.
    assign cpu_clk_en = run_step_s && !reset;
    assign cpu_rst    = reset || (state_r == ST_RST_HOLD);
    assign busy       = busy_r;
    assign done       = done_r;
    assign halted     = halted_r;
    assign cycles_run = cycles_run_r;

    // Main sequencer: state, latched run parameters, cycle counter and status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            rst_cnt_r    <= RST_ZERO;
            num_cycles_r <= CNT_ZERO;
            halt_en_r    <= 1'b0;
            halt_pc_r    <= {DATA_W{1'b0}};
            cycles_run_r <= CNT_ZERO;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            halted_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        num_cycles_r <= num_cycles;
                        halt_en_r    <= halt_en;
                        halt_pc_r    <= halt_pc;
                        cycles_run_r <= CNT_ZERO;
                        halted_r     <= 1'b0;
                        rst_cnt_r    <= RST_ZERO;
                        busy_r       <= 1'b1;
                        if (num_cycles == CNT_ZERO) begin
                            state_r <= ST_DONE;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= ST_RST_HOLD;
                        end
                    end
                end
                ST_RST_HOLD: begin
                    if (rst_cnt_r >= RST_LAST) begin
                        state_r <= ST_RUN;
                    end else begin
                        rst_cnt_r <= rst_cnt_r + RST_ONE;
                    end
                end
                ST_RUN: begin
                    if (halt_hit_s) begin
                        halted_r <= 1'b1;
                        state_r  <= ST_DONE;
                        done_r   <= 1'b1;
                    end else begin
                        cycles_run_r <= cycles_run_r + CNT_ONE;
                        if ((cycles_run_r + CNT_ONE) == num_cycles_r) begin
                            state_r <= ST_DONE;
                            done_r  <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

`ifdef MIPS_RUN_TRACE_EN
    localparam logic [AW:0] DEPTH_C   = (AW + 1)'(TRACE_DEPTH);
    localparam logic [AW:0] TCNT_ZERO = {(AW + 1){1'b0}};
    localparam logic [AW:0] TCNT_ONE  = (AW + 1)'(1);

    logic [DATA_W-1:0] trace_pc_mem  [TRACE_DEPTH];
    logic [DATA_W-1:0] trace_alu_mem [TRACE_DEPTH];
    logic [AW:0]       trace_count_r;
    logic              trace_overflow_r;
    logic [DATA_W-1:0] trace_pc_r;
    logic [DATA_W-1:0] trace_alu_r;
    logic              trace_we_s;

    // Write only while entries remain; later samples are dropped so the earliest history survives.
    always_comb begin
        if (run_step_s && !reset && (trace_count_r < DEPTH_C)) begin
            trace_we_s = 1'b1;
        end else begin
            trace_we_s = 1'b0;
        end
    end

    // Trace storage: plain write port, no reset so it maps onto RAM.
    always_ff @(posedge clk) begin
        if (trace_we_s) begin
            trace_pc_mem[trace_count_r[AW-1:0]]  <= pc_in;
            trace_alu_mem[trace_count_r[AW-1:0]] <= alu_result_in;
        end
    end

    // Registered read port; a same-cycle write to the addressed entry returns the old contents.
    always_ff @(posedge clk) begin
        if (reset) begin
            trace_pc_r  <= {DATA_W{1'b0}};
            trace_alu_r <= {DATA_W{1'b0}};
        end else begin
            trace_pc_r  <= trace_pc_mem[trace_rd_addr];
            trace_alu_r <= trace_alu_mem[trace_rd_addr];
        end
    end

    // Fill level and overflow flag, cleared when a new run is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            trace_count_r    <= TCNT_ZERO;
            trace_overflow_r <= 1'b0;
        end else if ((state_r == ST_IDLE) && start) begin
            trace_count_r    <= TCNT_ZERO;
            trace_overflow_r <= 1'b0;
        end else if (run_step_s) begin
            if (trace_count_r < DEPTH_C) begin
                trace_count_r <= trace_count_r + TCNT_ONE;
            end else begin
                trace_overflow_r <= 1'b1;
            end
        end
    end

    assign trace_pc       = trace_pc_r;
    assign trace_alu      = trace_alu_r;
    assign trace_count    = trace_count_r;
    assign trace_overflow = trace_overflow_r;
`else
    logic unused_trace_s;

    assign unused_trace_s = ^{trace_rd_addr, alu_result_in};
    assign trace_pc       = {DATA_W{1'b0}};
    assign trace_alu      = {DATA_W{1'b0}};
    assign trace_count    = {(AW + 1){1'b0}};
    assign trace_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_mips_run_controller.sv
// Randomised bench for mips_run_controller: a run-level reference model plus directed scenario pins.
module tb_mips_run_controller;

    localparam int DATA_W      = 32;
    localparam int CNT_W       = 16;
    localparam int RST_CYCLES  = 2;
    localparam int TRACE_DEPTH = 16;
    localparam int AW          = 4;
`ifdef MIPS_RUN_TRACE_EN
    localparam bit TRACE_ON = 1'b1;
`else
    localparam bit TRACE_ON = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [CNT_W-1:0]  num_cycles;
    logic              halt_en;
    logic [DATA_W-1:0] halt_pc;
    logic [DATA_W-1:0] pc_in;
    logic [DATA_W-1:0] alu_result_in;
    logic              cpu_rst;
    logic              cpu_clk_en;
    logic              busy;
    logic              done;
    logic              halted;
    logic [CNT_W-1:0]  cycles_run;
    logic [AW-1:0]     trace_rd_addr;
    logic [DATA_W-1:0] trace_pc;
    logic [DATA_W-1:0] trace_alu;
    logic [AW:0]       trace_count;
    logic              trace_overflow;

    mips_run_controller #(
        .DATA_W(DATA_W), .CNT_W(CNT_W), .RST_CYCLES(RST_CYCLES), .TRACE_DEPTH(TRACE_DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .num_cycles(num_cycles),
        .halt_en(halt_en), .halt_pc(halt_pc), .pc_in(pc_in), .alu_result_in(alu_result_in),
        .cpu_rst(cpu_rst), .cpu_clk_en(cpu_clk_en), .busy(busy), .done(done), .halted(halted),
        .cycles_run(cycles_run), .trace_rd_addr(trace_rd_addr), .trace_pc(trace_pc),
        .trace_alu(trace_alu), .trace_count(trace_count), .trace_overflow(trace_overflow)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Run-level reference model: position within the run, latched request, results, trace contents.
    bit                m_active;
    int                m_t;
    int                m_done_t;
    int                m_n;
    bit                m_hen;
    logic [DATA_W-1:0] m_hpc;
    int                m_cycles;
    bit                m_halted;
    int                m_tcount;
    bit                m_ovf;
    logic [DATA_W-1:0] m_mem_pc  [TRACE_DEPTH];
    logic [DATA_W-1:0] m_mem_alu [TRACE_DEPTH];
    bit                m_valid   [TRACE_DEPTH];
    logic [DATA_W-1:0] m_rd_pc;
    logic [DATA_W-1:0] m_rd_alu;
    bit                m_rd_known;

    int cyc, en_cnt, rst_cnt, done_pulses, done_at;
    bit jump_en, rand_addr, rand_alu;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit m_rst_win();
        return m_active && (m_n != 0) && (m_t >= 1) && (m_t <= RST_CYCLES);
    endfunction

    function automatic bit m_run_win();
        return m_active && (m_n != 0) && (m_done_t == 0) && (m_t > RST_CYCLES);
    endfunction

    function automatic bit m_hit();
        return m_run_win() && m_hen && (pc_in == m_hpc);
    endfunction

    task automatic model_reset();
        m_active = 1'b0; m_t = 0; m_done_t = 0; m_cycles = 0; m_halted = 1'b0;
        m_tcount = 0; m_ovf = 1'b0; m_rd_pc = '0; m_rd_alu = '0; m_rd_known = 1'b1;
    endtask

    task automatic compare_outputs();
        check("cpu_rst", cpu_rst, reset || m_rst_win());
        check("cpu_clk_en", cpu_clk_en, m_run_win() && !m_hit() && !reset);
        check("busy", busy, m_active);
        check("done", done, m_active && (m_t == m_done_t));
        check("halted", halted, m_halted);
        check("cycles_run", cycles_run, m_cycles);
        check("trace_count", trace_count, TRACE_ON ? m_tcount : 0);
        check("trace_overflow", trace_overflow, TRACE_ON ? m_ovf : 1'b0);
        if (!TRACE_ON || m_rd_known) begin
            check("trace_pc", trace_pc, TRACE_ON ? m_rd_pc : '0);
            check("trace_alu", trace_alu, TRACE_ON ? m_rd_alu : '0);
        end
    endtask

    // Advance the model across one clock edge using the inputs about to be sampled.
    task automatic model_edge();
        bit run, hit;
        run = m_run_win();
        hit = m_hit();
        if (reset) begin
            model_reset();
        end else begin
            m_rd_known = m_valid[trace_rd_addr];
            if (m_rd_known) begin
                m_rd_pc  = m_mem_pc[trace_rd_addr];
                m_rd_alu = m_mem_alu[trace_rd_addr];
            end
            if (!m_active) begin
                if (start) begin
                    m_active = 1'b1; m_t = 1; m_n = int'(num_cycles); m_hen = halt_en; m_hpc = halt_pc;
                    m_cycles = 0; m_halted = 1'b0; m_tcount = 0; m_ovf = 1'b0;
                    m_done_t = (m_n == 0) ? 1 : 0;
                end
            end else if (m_t == m_done_t) begin
                m_active = 1'b0;
            end else begin
                if (run && hit) begin
                    m_halted = 1'b1;
                    m_done_t = m_t + 1;
                end else if (run) begin
                    m_cycles++;
                    if (m_tcount < TRACE_DEPTH) begin
                        m_mem_pc[m_tcount] = pc_in; m_mem_alu[m_tcount] = alu_result_in;
                        m_valid[m_tcount] = 1'b1; m_tcount++;
                    end else begin
                        m_ovf = 1'b1;
                    end
                    if (m_cycles == m_n) m_done_t = m_t + 1;
                end
                m_t++;
            end
        end
    endtask

    // One clock: compare at the falling edge, step the model and the stand-in core, drive new inputs.
    task automatic step();
        logic [DATA_W-1:0] next_pc;
        @(negedge clk);
        compare_outputs();
        if (done === 1'b1) begin done_pulses++; done_at = cyc; end
        if (cpu_clk_en === 1'b1) en_cnt++;
        if (cpu_rst === 1'b1 && !reset) rst_cnt++;
        if (reset || m_rst_win()) next_pc = '0;
        else if (m_run_win() && !m_hit())
            next_pc = (jump_en && $urandom_range(0, 3) == 0) ? DATA_W'($urandom_range(0, 15) * 4) : pc_in + 32'd4;
        else next_pc = pc_in;
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
        pc_in = next_pc;
        alu_result_in = rand_alu ? DATA_W'($urandom) : next_pc + 32'd1;
        if (rand_addr) trace_rd_addr = AW'($urandom_range(0, TRACE_DEPTH - 1));
    endtask

    task automatic start_run(input int n, input bit hen, input logic [DATA_W-1:0] hpc);
        cyc = 0; en_cnt = 0; rst_cnt = 0; done_pulses = 0; done_at = -1;
        start = 1'b1; num_cycles = CNT_W'(n); halt_en = hen; halt_pc = hpc;
        step();
        start = 1'b0; num_cycles = CNT_W'($urandom_range(1, 300)); halt_en = ~hen;
    endtask

    task automatic finish_run(input int limit);
        int i;
        i = 0;
        while (busy === 1'b1 && i < limit) begin
            step();
            i++;
        end
        check("run_ends_in_budget", busy, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; num_cycles = '0; halt_en = 1'b0; halt_pc = '0;
        pc_in = '0; alu_result_in = 32'd1; trace_rd_addr = '0;
        jump_en = 1'b0; rand_addr = 1'b0; rand_alu = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_cpu_rst", cpu_rst, 1'b1);
        check("rst_clk_en", cpu_clk_en, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_halted", halted, 1'b0);
        check("rst_cycles_run", cycles_run, 0);
        check("rst_trace_count", trace_count, 0);
        check("rst_trace_pc", trace_pc, 0);
        reset = 1'b0;
        step();

        // Basic five-cycle run.
        start_run(5, 1'b0, '0);
        finish_run(50);
        check("s1_done_cycle", done_at, 8);
        check("s1_rst_cycles", rst_cnt, 2);
        check("s1_en_cycles", en_cnt, 5);
        check("s1_cycles_run", cycles_run, 5);
        check("s1_halted", halted, 1'b0);
        check("s1_done_pulses", done_pulses, 1);

        // Trace overflow and readback.
        start_run(20, 1'b0, '0);
        finish_run(60);
        trace_rd_addr = 4'd15;
        step();
        check("s2_trace_pc15", trace_pc, TRACE_ON ? 60 : 0);
        check("s2_trace_alu15", trace_alu, TRACE_ON ? 61 : 0);
        check("s2_trace_count", trace_count, TRACE_ON ? 16 : 0);
        check("s2_overflow", trace_overflow, TRACE_ON ? 1 : 0);
        check("s2_cycles_run", cycles_run, 20);
        trace_rd_addr = 4'd3;
        step();
        check("s2_trace_pc3", trace_pc, TRACE_ON ? 12 : 0);

        // PC-match halt.
        start_run(100, 1'b1, 32'd12);
        finish_run(150);
        check("s3_cycles_run", cycles_run, 3);
        check("s3_halted", halted, 1'b1);
        check("s3_en_cycles", en_cnt, 3);
        check("s3_done_pulses", done_pulses, 1);
        check("s3_done_cycle", done_at, 7);

        // Zero-cycle run.
        start_run(0, 1'b0, '0);
        finish_run(10);
        check("s4_done_cycle", done_at, 1);
        check("s4_rst_cycles", rst_cnt, 0);
        check("s4_en_cycles", en_cnt, 0);
        check("s4_cycles_run", cycles_run, 0);

        // Reset during the third RUN cycle.
        start_run(10, 1'b0, '0);
        repeat (4) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("s5_busy", busy, 1'b0);
        check("s5_clk_en", cpu_clk_en, 1'b0);
        check("s5_cycles_run", cycles_run, 0);
        repeat (5) step();
        check("s5_no_done", done_pulses, 0);

        // Start while busy is ignored.
        start_run(6, 1'b0, '0);
        repeat (3) step();
        start = 1'b1; num_cycles = 16'd2;
        step();
        start = 1'b0;
        finish_run(50);
        check("s6_cycles_run", cycles_run, 6);
        check("s6_en_cycles", en_cnt, 6);
        check("s6_done_pulses", done_pulses, 1);

        // Randomised runs with jumps, stray starts, random read addresses and occasional resets.
        jump_en = 1'b1; rand_addr = 1'b1; rand_alu = 1'b1;
        for (int r = 0; r < 40; r++) begin
            int i;
            start_run($urandom_range(0, 24), ($urandom_range(0, 2) == 0), DATA_W'($urandom_range(0, 15) * 4));
            i = 0;
            while (busy === 1'b1 && i < 100) begin
                start = ($urandom_range(0, 7) == 0);
                num_cycles = CNT_W'($urandom_range(0, 30));
                reset = ($urandom_range(0, 39) == 0);
                step();
                i++;
            end
            start = 1'b0; reset = 1'b0;
            check("rand_run_ends", busy, 1'b0);
            repeat ($urandom_range(1, 3)) step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
